// File: rtl/mem_access_stage_pkg.sv
// Pipe_Buf_Reg_PKG: pipeline buffer-register types shared by the MEM stage.
//   ex_mem_reg  - contents of the EX/MEM buffer register
//   mem_wb_reg  - contents of the MEM/WB buffer register
//   mem_state_t - MEM-stage access FSM states
//   F3_*        - load/store func3 encodings
package Pipe_Buf_Reg_PKG;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  RWSel;
    logic [31:0] Pc_Imm;
    logic [31:0] Pc_Four;
    logic [31:0] Imm_Out;
    logic [31:0] Alu_Result;
    logic [31:0] RD_Two;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [31:0] Curr_Instr;
  } ex_mem_reg;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic [1:0]  RWSel;
    logic [31:0] Pc_Imm;
    logic [31:0] Pc_Four;
    logic [31:0] Imm_Out;
    logic [31:0] Alu_Result;
    logic [31:0] MemReadData;
    logic [4:0]  rd;
    logic [31:0] Curr_Instr;
  } mem_wb_reg;

  // func3 encodings that no load/store uses.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// load_store_align: combinational sub-word formatting for the MEM stage.
//   func3, a    - access size/sign and byte offset within the word
//   store_data  - register value to be stored
//   rdata       - word returned by data memory
//   be          - store byte enables (caller gates with "is store")
//   wdata       - store data replicated across all lanes of its size
//   load_data   - selected lane, sign- or zero-extended per func3
//   misalign    - offset not aligned to the size, or func3 illegal
module load_store_align
  import Pipe_Buf_Reg_PKG::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  a,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection: byte by full offset, half by the upper offset bit.
  assign byte_sel = rdata[{a, 3'b000} +: 8];
  assign half_sel = rdata[{a[1], 4'b0000} +: 16];

  always_comb begin
    be        = 4'b0000;
    wdata     = 32'h0;
    load_data = 32'h0;
    misalign  = 1'b1;
    case (func3)
      F3_B: begin
        be        = 4'b0001 << a;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7]}}, byte_sel};
        misalign  = 1'b0;
      end
      F3_BU: begin
        be        = 4'b0001 << a;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'h0, byte_sel};
        misalign  = 1'b0;
      end
      F3_H: begin
        be        = 4'b0011 << {a[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_sel[15]}}, half_sel};
        misalign  = a[0];
      end
      F3_HU: begin
        be        = 4'b0011 << {a[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {16'h0, half_sel};
        misalign  = a[0];
      end
      F3_W: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        misalign  = (a != 2'b00);
      end
      default: begin
        misalign = f3_illegal(func3);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipelined MEM stage between EX/MEM and MEM/WB.
//   clk, reset              - clock, synchronous active-high reset
//   ex_mem_i/ex_mem_valid_i - incoming instruction (valid=0 is a bubble)
//   mem_stall_o             - combinational; upstream holds ex_mem_i while high
//   mem_wb_o/mem_wb_valid_o - registered MEM/WB contents
//   misalign_o              - one-cycle pulse on misaligned/illegal access
//   dmem_*                  - request/acknowledge data-memory port
// Non-memory ops pass through in one cycle. Aligned memory ops take one
// acceptance cycle (IDLE) plus one or more WAIT cycles ending on dmem_ack_i.
module mem_access_stage
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_reg         ex_mem_i,
  input  logic              ex_mem_valid_i,
  output logic              mem_stall_o,
  output mem_wb_reg         mem_wb_o,
  output logic              mem_wb_valid_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic [31:0]       dmem_rdata_i,
  input  logic              dmem_ack_i
);

  mem_state_t  state_reg;
  logic [2:0]  func3_reg;
  logic [1:0]  a_reg;

  logic        is_mem;
  logic        is_store;
  logic [2:0]  al_func3;
  logic [1:0]  al_a;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;
  logic        al_misalign;
  mem_wb_reg   wb_next;

  // MemRead wins when both bits are set.
  assign is_mem   = ex_mem_valid_i && (ex_mem_i.MemRead || ex_mem_i.MemWrite);
  assign is_store = !ex_mem_i.MemRead && ex_mem_i.MemWrite;

  // One formatter serves both phases: in IDLE it sees the incoming op
  // (store lanes, alignment); in WAIT it sees the latched op (load lane).
  assign al_func3 = (state_reg == WAIT) ? func3_reg : ex_mem_i.func3;
  assign al_a     = (state_reg == WAIT) ? a_reg : ex_mem_i.Alu_Result[1:0];

  load_store_align u_align (
    .func3      (al_func3),
    .a          (al_a),
    .store_data (ex_mem_i.RD_Two),
    .rdata      (dmem_rdata_i),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .misalign   (al_misalign)
  );

  // Stall drops in the ack cycle so upstream advances on the same edge
  // that loads mem_wb_o.
  always_comb begin
    mem_stall_o = 1'b0;
    case (state_reg)
      IDLE:    mem_stall_o = is_mem && !al_misalign;
      WAIT:    mem_stall_o = !dmem_ack_i;
      default: mem_stall_o = 1'b0;
    endcase
  end

  // Upstream holds ex_mem_i during WAIT, so pass-through fields can be
  // taken straight from it when the ack arrives.
  always_comb begin
    wb_next             = '0;
    wb_next.RegWrite    = ex_mem_i.RegWrite;
    wb_next.MemtoReg    = ex_mem_i.MemtoReg;
    wb_next.RWSel       = ex_mem_i.RWSel;
    wb_next.Pc_Imm      = ex_mem_i.Pc_Imm;
    wb_next.Pc_Four     = ex_mem_i.Pc_Four;
    wb_next.Imm_Out     = ex_mem_i.Imm_Out;
    wb_next.Alu_Result  = ex_mem_i.Alu_Result;
    wb_next.rd          = ex_mem_i.rd;
    wb_next.Curr_Instr  = ex_mem_i.Curr_Instr;
    wb_next.MemReadData = 32'h0;
    if (state_reg == WAIT) begin
      if (!dmem_we_o) begin
        wb_next.MemReadData = al_load_data;
      end
    end else if (is_mem && al_misalign) begin
      // A faulting access must not write the register file.
      wb_next.RegWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      func3_reg      <= 3'b000;
      a_reg          <= 2'b00;
      mem_wb_o       <= '0;
      mem_wb_valid_o <= 1'b0;
      misalign_o     <= 1'b0;
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_be_o      <= 4'b0000;
      dmem_wdata_o   <= 32'h0;
    end else begin
      mem_wb_valid_o <= 1'b0;
      misalign_o     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (is_mem && !al_misalign) begin
            state_reg    <= WAIT;
            func3_reg    <= ex_mem_i.func3;
            a_reg        <= ex_mem_i.Alu_Result[1:0];
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= is_store;
            dmem_addr_o  <= {ex_mem_i.Alu_Result[ADDR_W-1:2], 2'b00};
            dmem_be_o    <= is_store ? al_be : 4'b0000;
            dmem_wdata_o <= is_store ? al_wdata : 32'h0;
          end else begin
            mem_wb_o       <= wb_next;
            mem_wb_valid_o <= ex_mem_valid_i;
            misalign_o     <= is_mem && al_misalign;
          end
        end
        WAIT: begin
          if (dmem_ack_i) begin
            state_reg      <= IDLE;
            dmem_req_o     <= 1'b0;
            mem_wb_o       <= wb_next;
            mem_wb_valid_o <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
